fp_int_mul_seq: RTL and testbench

- Sequencer and result buffer in front of one bit-serial fp16 x int4 multiplier (fp_int_mul).
- Accepts {fp16 act, 4-bit sign-magnitude weight} operand pairs on a valid/ready stream and serialises the weight onto the multiplier's 1-bit w input over PRECISION cycles.
- Captures the {sign, exp, 14-bit mantissa} product when mul_start_acc pulses, buffers it in a 2-entry FIFO, and drives it out on a valid/ready stream to the downstream accumulator.

---
 rtl/fp_int_pkg.sv | 30 +++
 rtl/fp_int_mul_seq_if.sv | 43 ++++
 rtl/fp_int_res_fifo.sv | 48 ++++
 rtl/fp_int_mul_seq.sv | 135 +++++++++++++
 tb/tb_fp_int_mul_seq.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_int_pkg.sv
// Shared types and constants for the fp16 x int4 multiplier sequencer.
package fp_int_pkg;

    localparam int PRECISION  = 4;
    localparam int ACT_WIDTH  = 16;
    localparam int FP16_EXP_W = 5;
    localparam int FP16_MAN_W = 10;
    localparam int MANT_ACC_W = 14;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPT
    } seq_state_t;

    typedef struct packed {
        logic                  sign;
        logic [FP16_EXP_W-1:0] exp;
        logic [MANT_ACC_W-1:0] mant;
        logic                  zero;
    } res_t;

    // A zero exponent (zero/subnormal act) or zero weight magnitude gives an exact zero product.
    function automatic logic zero_operand(input logic [FP16_EXP_W-1:0] exp,
                                          input logic [PRECISION-2:0] mag);
        return (exp == '0) || (mag == '0);
    endfunction

endpackage

// File: rtl/fp_int_mul_seq_if.sv
// Operand stream, multiplier side-channel and result stream of the sequencer.
interface fp_int_mul_seq_if;
    import fp_int_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [ACT_WIDTH-1:0]  in_act;
    logic [PRECISION-1:0]  in_w;

    logic [ACT_WIDTH-1:0]  mul_act;
    logic                  mul_w;
    logic                  mul_valid;
    logic                  mul_sign;
    logic [FP16_EXP_W-1:0] mul_exp;
    logic [MANT_ACC_W-1:0] mul_mant;
    logic                  mul_start_acc;

    logic                  out_valid;
    logic                  out_ready;
    logic                  out_sign;
    logic [FP16_EXP_W-1:0] out_exp;
    logic [MANT_ACC_W-1:0] out_mant;
    logic                  out_zero;

    modport master (
        output in_valid, in_act, in_w,
        output mul_sign, mul_exp, mul_mant, mul_start_acc,
        output out_ready,
        input  in_ready,
        input  mul_act, mul_w, mul_valid,
        input  out_valid, out_sign, out_exp, out_mant, out_zero
    );

    modport slave (
        input  in_valid, in_act, in_w,
        input  mul_sign, mul_exp, mul_mant, mul_start_acc,
        input  out_ready,
        output in_ready,
        output mul_act, mul_w, mul_valid,
        output out_valid, out_sign, out_exp, out_mant, out_zero
    );

endinterface

// File: rtl/fp_int_res_fifo.sv
// Two-entry result buffer; the head entry is presented combinationally.
module fp_int_res_fifo
    import fp_int_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  res_t       push_data,
    input  logic       pop,
    output res_t       head,
    output logic [1:0] count
);

    res_t mem [FIFO_DEPTH];
    logic wr_ptr;
    logic rd_ptr;
    logic do_push;
    logic do_pop;

    assign do_push = push && (count != 2'(FIFO_DEPTH));
    assign do_pop  = pop && (count != 2'd0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fp_int_mul_seq.sv
// Serialises {fp16 act, int4 weight} pairs into the bit-serial multiplier and
// buffers its products for the downstream accumulator.
module fp_int_mul_seq
    import fp_int_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    fp_int_mul_seq_if.slave  bus
);

    seq_state_t            state;
    logic [1:0]            k;
    logic [PRECISION-2:0]  mag_q;
    logic [ACT_WIDTH-1:0]  act_q;
    logic                  mul_w_q;
    logic                  mul_valid_q;
    logic                  zero_q;
    logic                  capt_zero;
    logic                  pending;
    logic                  err;

    logic                  in_slot;
    logic                  busy;
    logic [2:0]            credit;
    logic                  in_ready;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  out_valid;
    logic [1:0]            fifo_count;
    res_t                  push_data;
    res_t                  head;

    // Credit counts the in-flight operation so a result always has a free slot.
    assign busy     = (state != IDLE);
    assign credit   = {1'b0, fifo_count} + {2'b00, busy};
    assign in_slot  = (state == IDLE) || ((state == ISSUE) && (k == 2'd3));
    assign in_ready = rst && in_slot && (credit < 3'(FIFO_DEPTH));
    assign accept   = bus.in_valid && in_ready;

    assign push      = (state == CAPT) && bus.mul_start_acc;
    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid && bus.out_ready;

    always_comb begin
        push_data.sign = bus.mul_sign;
        push_data.exp  = capt_zero ? '0 : bus.mul_exp;
        push_data.mant = capt_zero ? '0 : bus.mul_mant;
        push_data.zero = capt_zero;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            k           <= 2'd0;
            mag_q       <= '0;
            act_q       <= '0;
            mul_w_q     <= 1'b0;
            mul_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            capt_zero   <= 1'b0;
            pending     <= 1'b0;
            err         <= 1'b0;
        end else begin
            if (bus.mul_start_acc && (state != CAPT)) begin
                err <= 1'b1;
            end
            if (accept) begin
                mag_q       <= bus.in_w[PRECISION-2:0];
                act_q       <= bus.in_act;
                zero_q      <= zero_operand(bus.in_act[14:10], bus.in_w[PRECISION-2:0]);
                mul_w_q     <= bus.in_w[PRECISION-1];
                mul_valid_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= ISSUE;
                        k     <= 2'd0;
                    end
                end
                ISSUE: begin
                    if (k == 2'd3) begin
                        state     <= CAPT;
                        capt_zero <= zero_q;
                        pending   <= accept;
                        if (!accept) begin
                            mul_valid_q <= 1'b0;
                            mul_w_q     <= 1'b0;
                        end
                    end else begin
                        k       <= k + 2'd1;
                        mul_w_q <= mag_q[2'd2 - k];
                    end
                end
                CAPT: begin
                    // With a follow-on op pending, this cycle already was its k=0 slot.
                    if (pending) begin
                        if (!bus.mul_start_acc) begin
                            err <= 1'b1;
                        end
                        state   <= ISSUE;
                        k       <= 2'd1;
                        mul_w_q <= mag_q[2];
                        pending <= 1'b0;
                    end else if (bus.mul_start_acc) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fp_int_res_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    assign bus.in_ready  = in_ready;
    assign bus.mul_act   = act_q;
    assign bus.mul_w     = mul_w_q;
    assign bus.mul_valid = mul_valid_q;
    assign bus.out_valid = out_valid;
    assign bus.out_sign  = head.sign;
    assign bus.out_exp   = head.exp;
    assign bus.out_mant  = head.mant;
    assign bus.out_zero  = head.zero;

endmodule

// File: tb/tb_fp_int_mul_seq.sv
// Directed bench for fp_int_mul_seq with a behavioural stand-in for the serial multiplier.
module tb_fp_int_mul_seq;
    import fp_int_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic stray = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [3:0]  bits;
    int          hits;
    int          hit_at [2];
    logic [20:0] hit_data [2];
    logic        flag;

    fp_int_mul_seq_if bus ();

    fp_int_mul_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: gathers four serial bits, answers with the product one cycle later.
    initial begin : mul_model
        logic [3:0]  m_w;
        logic [15:0] m_act;
        int          m_cnt;
        logic        m_pend;
        logic        m_sign;
        logic [4:0]  m_exp;
        logic [13:0] m_mant;
        m_w = '0; m_act = '0; m_cnt = 0; m_pend = 1'b0;
        m_sign = 1'b0; m_exp = '0; m_mant = '0;
        bus.mul_start_acc = 1'b0;
        bus.mul_sign = 1'b0;
        bus.mul_exp = '0;
        bus.mul_mant = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_cnt = 0;
                m_pend = 1'b0;
                bus.mul_start_acc = 1'b0;
            end else begin
                bus.mul_start_acc = m_pend | stray;
                if (m_pend) begin
                    bus.mul_sign = m_sign;
                    bus.mul_exp  = m_exp;
                    bus.mul_mant = m_mant;
                end
                m_pend = 1'b0;
                if (bus.mul_valid) begin
                    if (m_cnt == 0) m_act = bus.mul_act;
                    m_w = {m_w[2:0], bus.mul_w};
                    m_cnt++;
                    if (m_cnt == 4) begin
                        m_cnt  = 0;
                        m_pend = 1'b1;
                        m_sign = m_act[15] ^ m_w[3];
                        m_exp  = m_act[14:10];
                        m_mant = {3'b000, 1'b1, m_act[9:0]} * {11'd0, m_w[2:0]};
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [3:0] w);
        bus.in_valid = v;
        bus.in_act   = a;
        bus.in_w     = w;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkResult(input string tag, input logic s, input logic [4:0] e,
                               input logic [13:0] m, input logic z);
        checkOutput({tag, " sign"}, 32'(bus.out_sign), 32'(s));
        checkOutput({tag, " exp"},  32'(bus.out_exp),  32'(e));
        checkOutput({tag, " mant"}, 32'(bus.out_mant), 32'(m));
        checkOutput({tag, " zero"}, 32'(bus.out_zero), 32'(z));
    endtask

    task automatic waitOut(input string tag, input int budget);
        int n;
        n = 0;
        while (!bus.out_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) checkOutput({tag, " out_valid timeout"}, 32'd0, 32'd1);
    endtask

    task automatic runOp(input string tag, input logic [15:0] a, input logic [3:0] w);
        applyStimulus(1'b1, a, w);
        @(negedge clk);
        applyStimulus(1'b0, 16'h0000, 4'h0);
        waitOut(tag, 12);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: observed no completion, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        applyStimulus(1'b0, 16'h0000, 4'h0);
        bus.out_ready = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset in_ready",  32'(bus.in_ready),  32'd0);
        checkOutput("reset mul_valid", 32'(bus.mul_valid), 32'd0);
        checkOutput("reset mul_w",     32'(bus.mul_w),     32'd0);
        checkOutput("reset mul_act",   32'(bus.mul_act),   32'd0);
        checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset out data",
                    32'({bus.out_sign, bus.out_exp, bus.out_mant, bus.out_zero}), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("idle in_ready", 32'(bus.in_ready), 32'd1);

        $display("[TB] single op 1.0 x +3");
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, 16'h3C00, 4'b0011);
        @(negedge clk);
        applyStimulus(1'b0, 16'h0000, 4'h0);
        bits[3] = bus.mul_w;
        checkOutput("t1 mul_act", 32'(bus.mul_act), 32'h3C00);
        checkOutput("t1 mul_valid k0", 32'(bus.mul_valid), 32'd1);
        for (int i = 2; i >= 0; i--) begin
            @(negedge clk);
            bits[i] = bus.mul_w;
            checkOutput("t1 mul_valid", 32'(bus.mul_valid), 32'd1);
        end
        checkOutput("t1 mul_w sequence", 32'(bits), 32'b0011);
        @(negedge clk);
        checkOutput("t1 out_valid before E+6", 32'(bus.out_valid), 32'd0);
        checkOutput("t1 mul_valid in CAPT", 32'(bus.mul_valid), 32'd0);
        @(negedge clk);
        checkOutput("t1 out_valid at E+6", 32'(bus.out_valid), 32'd1);
        checkResult("t1", 1'b0, 5'd15, 14'h0C00, 1'b0);
        @(negedge clk);
        checkOutput("t1 drained", 32'(bus.out_valid), 32'd0);

        $display("[TB] back-to-back ops");
        applyStimulus(1'b1, 16'hBC00, 4'b0101);
        hits = 0;
        hit_at[0] = -1;
        hit_at[1] = -1;
        hit_data[0] = '0;
        hit_data[1] = '0;
        flag = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 1) applyStimulus(1'b1, 16'h4000, 4'b1111);
            if (n == 4) checkOutput("t2 in_ready at k3", 32'(bus.in_ready), 32'd1);
            if (n == 5) begin
                applyStimulus(1'b0, 16'h0000, 4'h0);
                checkOutput("t2 overlap mul_w", 32'(bus.mul_w), 32'd1);
                checkOutput("t2 overlap mul_act", 32'(bus.mul_act), 32'h4000);
            end
            if (n <= 8 && bus.mul_valid !== 1'b1) flag = 1'b1;
            if (bus.out_valid && hits < 2) begin
                hit_at[hits]   = n;
                hit_data[hits] = {bus.out_sign, bus.out_exp, bus.out_mant, bus.out_zero};
                hits++;
            end
        end
        checkOutput("t2 mul_valid dropped", 32'(flag), 32'd0);
        checkOutput("t2 result count", 32'(hits), 32'd2);
        checkOutput("t2 first result cycle", 32'(hit_at[0]), 32'd6);
        checkOutput("t2 second result cycle", 32'(hit_at[1]), 32'd10);
        checkOutput("t2 first result", 32'(hit_data[0]), 32'({1'b1, 5'd15, 14'h1400, 1'b0}));
        checkOutput("t2 second result", 32'(hit_data[1]), 32'({1'b1, 5'd16, 14'h1C00, 1'b0}));

        $display("[TB] backpressure with three ops");
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 16'h3C00, 4'b0001);
        flag = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 1) applyStimulus(1'b1, 16'h3C00, 4'b0010);
            if (n == 4) checkOutput("t3 in_ready for second op", 32'(bus.in_ready), 32'd1);
            if (n == 5) applyStimulus(1'b1, 16'h3C00, 4'b0011);
            if (n >= 5 && bus.in_ready) flag = 1'b1;
        end
        checkOutput("t3 in_ready after second accept", 32'(flag), 32'd0);
        checkOutput("t3 out_valid held", 32'(bus.out_valid), 32'd1);
        checkOutput("t3 head first", 32'(bus.out_mant), 32'h0400);
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("t3 head second", 32'(bus.out_mant), 32'h0800);
        checkOutput("t3 in_ready after pop", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        applyStimulus(1'b0, 16'h0000, 4'h0);
        checkOutput("t3 third op issuing", 32'(bus.mul_valid), 32'd1);
        waitOut("t3 third", 12);
        checkOutput("t3 head third", 32'(bus.out_mant), 32'h0C00);
        @(negedge clk);
        checkOutput("t3 drained", 32'(bus.out_valid), 32'd0);

        $display("[TB] zero operands");
        runOp("t4a", 16'h3C00, 4'b1000);
        checkResult("t4a", 1'b1, 5'd0, 14'h0000, 1'b1);
        runOp("t4b", 16'h0000, 4'b0111);
        checkResult("t4b", 1'b0, 5'd0, 14'h0000, 1'b1);
        @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("stray start_acc ignored", 32'(bus.out_valid), 32'd0);
        checkOutput("stray in_ready", 32'(bus.in_ready), 32'd1);

        $display("[TB] reset mid-operation");
        bus.out_ready = 1'b0;
        runOp("t5 buffered", 16'h3C00, 4'b0011);
        applyStimulus(1'b1, 16'h4000, 4'b0010);
        @(negedge clk);
        applyStimulus(1'b0, 16'h0000, 4'h0);
        repeat (2) @(negedge clk);
        checkOutput("t5 issuing before reset", 32'(bus.mul_valid), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("t5 reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("t5 reset out data",
                    32'({bus.out_sign, bus.out_exp, bus.out_mant, bus.out_zero}), 32'd0);
        checkOutput("t5 reset mul_valid", 32'(bus.mul_valid), 32'd0);
        checkOutput("t5 reset mul_act", 32'(bus.mul_act), 32'd0);
        checkOutput("t5 reset in_ready", 32'(bus.in_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t5 no stale result", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        runOp("t5 fresh", 16'h4000, 4'b0011);
        checkResult("t5 fresh", 1'b0, 5'd16, 14'h0C00, 1'b0);
        @(negedge clk);
        checkOutput("t5 drained", 32'(bus.out_valid), 32'd0);

        $display("[TB] simultaneous push and pop");
        bus.out_ready = 1'b0;
        runOp("t6 first", 16'h3C00, 4'b0001);
        applyStimulus(1'b1, 16'h3C00, 4'b0010);
        @(negedge clk);
        applyStimulus(1'b0, 16'h0000, 4'h0);
        repeat (4) @(negedge clk);
        checkOutput("t6 head before swap", 32'(bus.out_mant), 32'h0400);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput("t6 out_valid after swap", 32'(bus.out_valid), 32'd1);
        checkOutput("t6 head after swap", 32'(bus.out_mant), 32'h0800);
        @(negedge clk);
        checkOutput("t6 head held", 32'(bus.out_mant), 32'h0800);
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("t6 single entry left", 32'(bus.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
